// File: rtl/rv_m_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with a single-cycle path for divide-by-zero and signed-overflow divides.
module rv_m_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_start,
  input  logic [2:0]      m_funct3,
  input  logic [XLEN-1:0] m_rs1,
  input  logic [XLEN-1:0] m_rs2,
  output logic            m_busy,
  output logic            rv_m_ready,
  output logic [XLEN-1:0] m_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] b_q, b_d;       // multiplicand / divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier bits / dividend bits becoming quotient
  logic [XLEN-1:0] result_q, result_d;

  // acceptance-time decode
  logic            a_signed, b_signed, a_neg, b_neg, is_div;
  logic            div_zero, div_ovf, is_fast, acc_neg;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  // one iteration step
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_hi_nxt, div_lo_nxt;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   calc_res;
  logic              last_step;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Decode the incoming op: signedness, magnitudes and the single-cycle special cases
  always_comb begin
    a_signed = (m_funct3 == F_MULH) || (m_funct3 == F_MULHSU) ||
               (m_funct3 == F_DIV)  || (m_funct3 == F_REM);
    b_signed = (m_funct3 == F_MULH) || (m_funct3 == F_DIV) || (m_funct3 == F_REM);
    a_neg    = a_signed & m_rs1[XLEN-1];
    b_neg    = b_signed & m_rs2[XLEN-1];
    a_mag    = cond_neg(m_rs1, a_neg);
    b_mag    = cond_neg(m_rs2, b_neg);
    is_div   = m_funct3[2];
    div_zero = is_div && (m_rs2 == '0);
    div_ovf  = ((m_funct3 == F_DIV) || (m_funct3 == F_REM)) &&
               (m_rs1 == MIN_VAL) && (m_rs2 == '1);
    is_fast  = div_zero || div_ovf;
    if (div_zero) fast_res = m_funct3[1] ? m_rs1 : '1;
    else          fast_res = m_funct3[1] ? '0 : m_rs1;
    // remainder follows the dividend sign; everything else follows the sign product
    acc_neg  = (is_div && m_funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One shift-add / restoring-divide step and the result that the final step produces
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_nxt = mul_sum[XLEN:1];
    mul_lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};

    div_shift  = {hi_q, lo_q[XLEN-1]};
    div_ge     = (div_shift >= {1'b0, b_q});
    // the true difference is below the divisor, so the low XLEN bits are exact
    div_hi_nxt = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
    div_lo_nxt = {lo_q[XLEN-2:0], div_ge};

    prod_s     = cond_neg2({mul_hi_nxt, mul_lo_nxt}, neg_q);
    last_step  = (cnt_q == CW'(XLEN-1));

    case (op_q)
      F_MUL:                      calc_res = prod_s[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  calc_res = prod_s[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              calc_res = cond_neg(div_lo_nxt, neg_q);
      F_REM, F_REMU:              calc_res = cond_neg(div_hi_nxt, neg_q);
      default:                    calc_res = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (m_start) state_d = is_fast ? S_DONE : S_CALC;
      S_CALC:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load on acceptance, step while calculating
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (m_start) begin
          op_d  = m_funct3;
          neg_d = acc_neg;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = a_mag;
          b_d   = b_mag;
          if (is_fast) result_d = fast_res;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[2]) begin
          hi_d = div_hi_nxt;
          lo_d = div_lo_nxt;
        end else begin
          hi_d = mul_hi_nxt;
          lo_d = mul_lo_nxt;
        end
        if (last_step) result_d = calc_res;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  // Outputs decoded from state
  always_comb begin
    m_busy     = (state_q != S_IDLE);
    rv_m_ready = (state_q == S_DONE);
    m_result   = result_q;
  end

endmodule
